pe_dispatch: RTL and testbench

- Initiator-side controller for one butterfly PE (pe3-class: a/b/w/tf/ctrl/valid in, u/v/valid out, fixed latency, no backpressure).
- Accepts operation requests over a valid/ready handshake and issues them to the PE.
- Enforces drain-before-mode-switch and credit-based flow control.
- Collects PE results into a response FIFO with valid/ready output, tagged with the issuing mode.

---
 rtl/poly_arith_pkg.sv | 30 +++
 rtl/pe_dispatch_if.sv | 32 +++
 rtl/pe_rsp_fifo.sv | 56 +++++
 rtl/pe_dispatch.sv | 146 ++++++++++++++
 tb/tb_pe_dispatch.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_arith_pkg.sv
// Shared arithmetic types for the polynomial datapath.
//   coeff_t   : one coefficient word
//   pe_mode_e : butterfly PE operation mode
//   pe_rsp_t  : one PE result plus the mode it was computed in
//   disp_state_e : pe_dispatch controller states
package poly_arith_pkg;

   localparam int COEFF_W = 16;

   typedef logic [COEFF_W-1:0] coeff_t;

   typedef enum logic [1:0] {
      PE_MODE_NTT    = 2'd0,
      PE_MODE_INTT   = 2'd1,
      PE_MODE_CWM    = 2'd2,
      PE_MODE_ADDSUB = 2'd3
   } pe_mode_e;

   typedef struct packed {
      coeff_t   u;
      coeff_t   v;
      pe_mode_e mode;
   } pe_rsp_t;

   typedef enum logic {
      DISP_RUN   = 1'b0,
      DISP_DRAIN = 1'b1
   } disp_state_e;

endpackage

// File: rtl/pe_dispatch_if.sv
// Request and response channels of pe_dispatch.
//   req_* : operation requests, valid/ready handshake (master drives valid/data)
//   rsp_* : buffered PE results, valid/ready handshake (master drives ready)
// master = the client issuing requests and consuming responses, slave = pe_dispatch.
interface pe_dispatch_if;
   import poly_arith_pkg::*;

   logic     req_valid_i;
   logic     req_ready_o;
   coeff_t   req_a_i;
   coeff_t   req_b_i;
   coeff_t   req_w_i;
   coeff_t   req_tf_i;
   pe_mode_e req_mode_i;

   logic     rsp_valid_o;
   logic     rsp_ready_i;
   coeff_t   rsp_u_o;
   coeff_t   rsp_v_o;
   pe_mode_e rsp_mode_o;

   modport master (
      output req_valid_i, req_a_i, req_b_i, req_w_i, req_tf_i, req_mode_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_u_o, rsp_v_o, rsp_mode_o
   );

   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_w_i, req_tf_i, req_mode_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_u_o, rsp_v_o, rsp_mode_o
   );

endinterface

// File: rtl/pe_rsp_fifo.sv
// First-word-fall-through FIFO of pe_rsp_t.
//   clk, rst   : clock, synchronous active-low reset
//   push_valid : write push_data this cycle (caller guarantees room)
//   pop_ready  : consume the head when head_valid
//   head_valid : FIFO non-empty; head_data shows the oldest entry combinationally
//   count      : number of stored entries (registered)
module pe_rsp_fifo
   import poly_arith_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   input  pe_rsp_t          push_data,
   input  logic             pop_ready,
   output logic             head_valid,
   output pe_rsp_t          head_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   // Read is combinational for fall-through, so this maps to distributed RAM.
   pe_rsp_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_pop;

   assign head_valid = (count_reg != '0);
   assign do_pop     = pop_ready && head_valid;
   assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;
   assign count      = count_reg;

   always_ff @(posedge clk) begin
      if (push_valid) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_valid) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_reg + CNT_W'(push_valid) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/pe_dispatch.sv
// Initiator-side controller for one fixed-latency butterfly PE.
//   clk, rst      : clock, synchronous active-low reset (PE is reset alongside)
//   bus           : request channel in, response channel out (pe_dispatch_if.slave)
//   pe_*_o        : registered operands, mode and valid towards the PE
//   pe_u_i/v_i    : PE results, qualified by pe_valid_i
//   busy_o        : ops in flight, responses buffered, or draining for a mode switch
//   err_ghost_o   : sticky, a PE result arrived with nothing in flight
// A mode switch waits until the PE is empty; credits cover in-flight ops plus
// buffered responses so the response FIFO can never overflow.
module pe_dispatch
   import poly_arith_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst,
   pe_dispatch_if.slave bus,
   output coeff_t       pe_a_o,
   output coeff_t       pe_b_o,
   output coeff_t       pe_w_o,
   output coeff_t       pe_tf_o,
   output pe_mode_e     pe_ctrl_o,
   output logic         pe_valid_o,
   input  coeff_t       pe_u_i,
   input  coeff_t       pe_v_i,
   input  logic         pe_valid_i,
   output logic         busy_o,
   output logic         err_ghost_o
);

   disp_state_e      state_reg, state_next;
   pe_mode_e         cur_mode_reg;
   logic [CNT_W-1:0] in_flight_reg;
   logic [CNT_W-1:0] fifo_count;
   coeff_t           pe_a_reg, pe_b_reg, pe_w_reg, pe_tf_reg;
   logic             pe_valid_reg;
   logic             err_ghost_reg;

   logic             req_ready;
   logic             accept;
   logic             capture;
   logic             ghost;
   logic             mode_match;
   logic             pe_empty;
   logic             credit_ok;
   logic [CNT_W:0]   credit_sum;
   pe_rsp_t          push_data;
   pe_rsp_t          head;

   assign mode_match = (bus.req_mode_i == cur_mode_reg);
   assign pe_empty   = (in_flight_reg == '0);
   // Registered counts only: a pop this cycle frees its credit next cycle.
   assign credit_sum = {1'b0, in_flight_reg} + {1'b0, fifo_count};
   assign credit_ok  = (credit_sum < (CNT_W+1)'(FIFO_DEPTH));

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      case (state_reg)
         DISP_RUN: begin
            req_ready = credit_ok && (mode_match || pe_empty);
            if (bus.req_valid_i && !mode_match && !pe_empty) begin
               state_next = DISP_DRAIN;
            end
         end
         DISP_DRAIN: begin
            if (pe_empty) begin
               state_next = DISP_RUN;
            end
         end
         default: state_next = DISP_RUN;
      endcase
   end

   assign accept  = bus.req_valid_i && req_ready;
   assign capture = pe_valid_i && !pe_empty;
   assign ghost   = pe_valid_i && pe_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= DISP_RUN;
         cur_mode_reg  <= PE_MODE_NTT;
         in_flight_reg <= '0;
         pe_a_reg      <= '0;
         pe_b_reg      <= '0;
         pe_w_reg      <= '0;
         pe_tf_reg     <= '0;
         pe_valid_reg  <= 1'b0;
         err_ghost_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pe_valid_reg <= accept;
         if (accept) begin
            pe_a_reg     <= bus.req_a_i;
            pe_b_reg     <= bus.req_b_i;
            pe_w_reg     <= bus.req_w_i;
            pe_tf_reg    <= bus.req_tf_i;
            // Only differs from the current mode when the PE is empty.
            cur_mode_reg <= bus.req_mode_i;
         end
         case ({accept, capture})
            2'b10:   in_flight_reg <= in_flight_reg + CNT_W'(1);
            2'b01:   in_flight_reg <= in_flight_reg - CNT_W'(1);
            default: in_flight_reg <= in_flight_reg;
         endcase
         if (ghost) begin
            err_ghost_reg <= 1'b1;
         end
      end
   end

   // Results are tagged with cur_mode_reg: it cannot change while ops are in flight.
   assign push_data.u    = pe_u_i;
   assign push_data.v    = pe_v_i;
   assign push_data.mode = cur_mode_reg;

   pe_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (capture),
      .push_data  (push_data),
      .pop_ready  (bus.rsp_ready_i),
      .head_valid (bus.rsp_valid_o),
      .head_data  (head),
      .count      (fifo_count)
   );

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_u_o     = head.u;
   assign bus.rsp_v_o     = head.v;
   assign bus.rsp_mode_o  = head.mode;

   assign pe_a_o      = pe_a_reg;
   assign pe_b_o      = pe_b_reg;
   assign pe_w_o      = pe_w_reg;
   assign pe_tf_o     = pe_tf_reg;
   assign pe_ctrl_o   = cur_mode_reg;
   assign pe_valid_o  = pe_valid_reg;
   assign err_ghost_o = err_ghost_reg;
   assign busy_o      = !pe_empty || (fifo_count != '0) || (state_reg == DISP_DRAIN);

endmodule

// File: tb/tb_pe_dispatch.sv
// Bench for pe_dispatch with a 3-cycle PE model and a response scoreboard.
module tb_pe_dispatch;
   import poly_arith_pkg::*;

   localparam int FIFO_DEPTH = 8;
   localparam int PE_LAT     = 3;
   localparam int N_RAND     = 500;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pe_dispatch_if bus();
   coeff_t   pe_a, pe_b, pe_w, pe_tf, pe_u, pe_v;
   pe_mode_e pe_ctrl;
   logic     pe_valid_o, pe_valid_i, busy, err_ghost;
   logic     ghost_inj = 1'b0;

   pe_dispatch #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .pe_a_o      (pe_a),
      .pe_b_o      (pe_b),
      .pe_w_o      (pe_w),
      .pe_tf_o     (pe_tf),
      .pe_ctrl_o   (pe_ctrl),
      .pe_valid_o  (pe_valid_o),
      .pe_u_i      (pe_u),
      .pe_v_i      (pe_v),
      .pe_valid_i  (pe_valid_i),
      .busy_o      (busy),
      .err_ghost_o (err_ghost)
   );

   function automatic coeff_t model_u(coeff_t a, coeff_t b, coeff_t w);
      return a + b * w;
   endfunction

   function automatic coeff_t model_v(coeff_t a, coeff_t b, coeff_t tf);
      return a - b * tf;
   endfunction

   // ---------------- PE model: fixed latency, reset with the DUT ----------------
   logic [PE_LAT-1:0] s_valid;
   coeff_t            s_u [PE_LAT];
   coeff_t            s_v [PE_LAT];

   always @(posedge clk) begin
      if (!rst) s_valid <= '0;
      else      s_valid <= {s_valid[PE_LAT-2:0], pe_valid_o};
      s_u[0] <= model_u(pe_a, pe_b, pe_w);
      s_v[0] <= model_v(pe_a, pe_b, pe_tf);
      for (int i = 1; i < PE_LAT; i++) begin
         s_u[i] <= s_u[i-1];
         s_v[i] <= s_v[i-1];
      end
   end

   assign pe_u       = s_u[PE_LAT-1];
   assign pe_v       = s_v[PE_LAT-1];
   assign pe_valid_i = s_valid[PE_LAT-1] | ghost_inj;

   // ---------------- Scoreboard / monitor (negedge) ----------------
   pe_rsp_t  sb_q[$];
   pe_rsp_t  mon_exp, mon_got;
   int       checks = 0, failures = 0, rsp_seen = 0, cyc = 0;
   int       cnt_prev = 0, cnt_now = 0, cnt_next = 0;
   int       run_len = 0, run_max = 0;
   pe_mode_e last_ctrl = PE_MODE_NTT;
   bit       mon_acc, mon_cap;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         sb_q.delete();
         cnt_prev  = 0;
         cnt_now   = 0;
         cnt_next  = 0;
         run_len   = 0;
         last_ctrl = PE_MODE_NTT;
      end else begin
         cnt_prev = cnt_now;
         cnt_now  = cnt_next;
         if (pe_ctrl !== last_ctrl) begin
            checks++;
            if (cnt_prev != 0) begin
               failures++;
               $display("FAIL ctrl_stable: pe_ctrl_o changed %0d->%0d with %0d in flight, required 0 in flight",
                        last_ctrl, pe_ctrl, cnt_prev);
            end
            last_ctrl = pe_ctrl;
         end
         mon_acc = bus.req_valid_i && bus.req_ready_o;
         mon_cap = pe_valid_i && (cnt_now != 0);
         if (mon_acc) begin
            mon_exp.u    = model_u(bus.req_a_i, bus.req_b_i, bus.req_w_i);
            mon_exp.v    = model_v(bus.req_a_i, bus.req_b_i, bus.req_tf_i);
            mon_exp.mode = bus.req_mode_i;
            sb_q.push_back(mon_exp);
         end
         cnt_next = cnt_now + int'(mon_acc) - int'(mon_cap);
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            checks++;
            mon_got.u    = bus.rsp_u_o;
            mon_got.v    = bus.rsp_v_o;
            mon_got.mode = bus.rsp_mode_o;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got u=%h v=%h mode=%0d, required no response",
                        mon_got.u, mon_got.v, mon_got.mode);
            end else begin
               mon_exp = sb_q.pop_front();
               rsp_seen++;
               if (mon_got !== mon_exp) begin
                  failures++;
                  $display("FAIL sb_rsp: got u=%h v=%h mode=%0d, required u=%h v=%h mode=%0d",
                           mon_got.u, mon_got.v, mon_got.mode, mon_exp.u, mon_exp.v, mon_exp.mode);
               end
            end
         end
         if (pe_valid_o) run_len++;
         else            run_len = 0;
         if (run_len > run_max) run_max = run_len;
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_req(input coeff_t a, input coeff_t b, input coeff_t w,
                            input coeff_t tf, input pe_mode_e m);
      bus.req_valid_i = 1'b1;
      bus.req_a_i     = a;
      bus.req_b_i     = b;
      bus.req_w_i     = w;
      bus.req_tf_i    = tf;
      bus.req_mode_i  = m;
   endtask

   // Call just after a posedge; returns just after the accepting posedge.
   task automatic send(input coeff_t a, input coeff_t b, input coeff_t w, input coeff_t tf,
                       input pe_mode_e m, input int bound, output int waited);
      waited = 0;
      drive_req(a, b, w, tf, m);
      forever begin
         wait_neg();
         if (bus.req_ready_o) break;
         waited++;
         if (waited >= bound) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: req_ready_o stayed 0 for %0d cycles, required accept", waited);
            bus.req_valid_i = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      wait_neg();
      while (sb_q.size() != 0 || busy) begin
         n++;
         if (n >= bound) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses pending, busy=%0b, required drained", sb_q.size(), busy);
            return;
         end
         wait_neg();
      end
   endtask

   // ---------------- Scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      wait_neg();
      checks++; if (pe_valid_o !== 1'b0) begin failures++; $display("FAIL rst_pe_valid: got %0b required 0", pe_valid_o); end
      checks++; if ({pe_a, pe_b, pe_w, pe_tf} !== 64'h0) begin failures++; $display("FAIL rst_pe_data: got %h required 0", {pe_a, pe_b, pe_w, pe_tf}); end
      checks++; if (pe_ctrl !== PE_MODE_NTT) begin failures++; $display("FAIL rst_pe_ctrl: got %0d required %0d", pe_ctrl, PE_MODE_NTT); end
      checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %0b required 0", bus.rsp_valid_o); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b required 0", busy); end
      checks++; if (err_ghost !== 1'b0) begin failures++; $display("FAIL rst_err_ghost: got %0b required 0", err_ghost); end
      @(posedge clk); #1;
      rst = 1'b1;
      wait_neg();
      checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %0b required 1", bus.req_ready_o); end
   endtask

   task automatic test_stream();
      int w, total = 0, seen0 = rsp_seen;
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      run_max = 0;
      for (int i = 0; i < 6; i++) begin
         send(coeff_t'(16'h0100 + i), coeff_t'(16'h0020 + 3 * i), coeff_t'(i + 2), coeff_t'(16'h0005 + i), PE_MODE_NTT, 20, w);
         total += w;
      end
      bus.req_valid_i = 1'b0;
      wait_drain(100);
      checks++; if (total !== 0) begin failures++; $display("FAIL stream_stalls: got %0d stall cycles required 0", total); end
      checks++; if (run_max !== 6) begin failures++; $display("FAIL stream_issue_run: got %0d consecutive pe_valid_o required 6", run_max); end
      checks++; if (rsp_seen - seen0 !== 6) begin failures++; $display("FAIL stream_rsp_count: got %0d required 6", rsp_seen - seen0); end
   endtask

   task automatic test_mode_switch();
      int w, zero_cyc = -1, acc_cyc = -1, seen0 = rsp_seen;
      bit first = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         send(coeff_t'(16'h0A00 + i), coeff_t'(16'h0011 + i), coeff_t'(7), coeff_t'(9), PE_MODE_NTT, 20, w);
      end
      drive_req(16'h0B00, 16'h0033, 16'd4, 16'd6, PE_MODE_INTT);
      for (int k = 0; k < 100; k++) begin
         wait_neg();
         if (first) begin
            checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("FAIL switch_ready_drop: got %0b required 0", bus.req_ready_o); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL switch_busy: got %0b required 1", busy); end
            first = 1'b0;
         end
         if (cnt_now == 0 && zero_cyc < 0) zero_cyc = cyc;
         checks++; if (pe_ctrl !== PE_MODE_NTT) begin failures++; $display("FAIL switch_ctrl_hold: got %0d required %0d", pe_ctrl, PE_MODE_NTT); end
         if (bus.req_ready_o) begin
            acc_cyc = cyc;
            break;
         end
      end
      checks++;
      if (acc_cyc < 0 || zero_cyc < 0 || acc_cyc <= zero_cyc) begin
         failures++;
         $display("FAIL switch_drain_order: accept cycle %0d, empty cycle %0d, required accept after empty", acc_cyc, zero_cyc);
      end
      @(posedge clk); #1;
      drive_req(16'h0B01, 16'h0044, 16'd5, 16'd8, PE_MODE_INTT);
      wait_neg();
      checks++; if (pe_valid_o !== 1'b1) begin failures++; $display("FAIL switch_first_issue: got pe_valid_o=%0b required 1", pe_valid_o); end
      checks++; if (pe_ctrl !== PE_MODE_INTT) begin failures++; $display("FAIL switch_new_ctrl: got %0d required %0d", pe_ctrl, PE_MODE_INTT); end
      checks++; if (pe_a !== 16'h0B00) begin failures++; $display("FAIL switch_issue_a: got %h required 0b00", pe_a); end
      checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL switch_second_ready: got %0b required 1", bus.req_ready_o); end
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      wait_drain(100);
      checks++; if (rsp_seen - seen0 !== 5) begin failures++; $display("FAIL switch_rsp_count: got %0d required 5", rsp_seen - seen0); end
   endtask

   task automatic test_backpressure();
      int w, acc = 0, idx = 0, seen0 = rsp_seen;
      bus.rsp_ready_i = 1'b0;
      @(posedge clk); #1;
      drive_req(coeff_t'(16'hC000), coeff_t'(16'h0101), 16'd3, 16'd2, PE_MODE_CWM);
      for (int k = 0; k < 40; k++) begin
         wait_neg();
         if (bus.req_ready_o) begin
            acc++;
            idx++;
         end
         @(posedge clk); #1;
         drive_req(coeff_t'(16'hC000 + idx), coeff_t'(16'h0101 + idx), 16'd3, 16'd2, PE_MODE_CWM);
      end
      wait_neg();
      checks++; if (acc !== FIFO_DEPTH) begin failures++; $display("FAIL bp_accepted: got %0d required %0d", acc, FIFO_DEPTH); end
      checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %0b required 0", bus.req_ready_o); end
      checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid: got %0b required 1", bus.rsp_valid_o); end
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b1;
      for (int i = idx; i < 12; i++) begin
         send(coeff_t'(16'hC000 + i), coeff_t'(16'h0101 + i), 16'd3, 16'd2, PE_MODE_CWM, 40, w);
      end
      bus.req_valid_i = 1'b0;
      wait_drain(200);
      checks++; if (rsp_seen - seen0 !== 12) begin failures++; $display("FAIL bp_rsp_count: got %0d required 12", rsp_seen - seen0); end
   endtask

   task automatic test_ghost();
      wait_drain(100);
      checks++; if (err_ghost !== 1'b0) begin failures++; $display("FAIL ghost_pre: got %0b required 0", err_ghost); end
      @(posedge clk); #1;
      ghost_inj = 1'b1;
      @(posedge clk); #1;
      ghost_inj = 1'b0;
      wait_neg();
      checks++; if (err_ghost !== 1'b1) begin failures++; $display("FAIL ghost_flag: got %0b required 1", err_ghost); end
      checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL ghost_fifo_empty: got rsp_valid_o=%0b required 0", bus.rsp_valid_o); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ghost_busy: got %0b required 0", busy); end
      repeat (3) wait_neg();
      checks++; if (err_ghost !== 1'b1) begin failures++; $display("FAIL ghost_sticky: got %0b required 1", err_ghost); end
   endtask

   task automatic test_reset_mid();
      int w, seen0;
      bus.rsp_ready_i = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) send(coeff_t'(16'hD000 + i), 16'h0002, 16'd3, 16'd4, PE_MODE_ADDSUB, 20, w);
      bus.req_valid_i = 1'b0;
      repeat (8) wait_neg();
      checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("FAIL midrst_buffered: got rsp_valid_o=%0b required 1", bus.rsp_valid_o); end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) send(coeff_t'(16'hD010 + i), 16'h0003, 16'd5, 16'd6, PE_MODE_ADDSUB, 20, w);
      bus.req_valid_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      wait_neg();
      checks++; if (pe_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_pe_valid: got %0b required 0", pe_valid_o); end
      checks++; if ({pe_a, pe_b, pe_w, pe_tf} !== 64'h0) begin failures++; $display("FAIL midrst_pe_data: got %h required 0", {pe_a, pe_b, pe_w, pe_tf}); end
      checks++; if (pe_ctrl !== PE_MODE_NTT) begin failures++; $display("FAIL midrst_pe_ctrl: got %0d required %0d", pe_ctrl, PE_MODE_NTT); end
      checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid: got %0b required 0", bus.rsp_valid_o); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b required 0", busy); end
      checks++; if (err_ghost !== 1'b0) begin failures++; $display("FAIL midrst_err_ghost: got %0b required 0", err_ghost); end
      seen0 = rsp_seen;
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      send(16'hE123, 16'h0456, 16'd7, 16'd9, PE_MODE_ADDSUB, 20, w);
      bus.req_valid_i = 1'b0;
      wait_drain(100);
      checks++; if (rsp_seen - seen0 !== 1) begin failures++; $display("FAIL midrst_after: got %0d responses required 1", rsp_seen - seen0); end
   endtask

   task automatic test_random();
      int       w, seen0 = rsp_seen;
      bit       done = 1'b0;
      pe_mode_e m = PE_MODE_NTT;
      fork
         begin
            @(posedge clk); #1;
            for (int n = 0; n < N_RAND; n++) begin
               if ($urandom_range(3) == 0) m = pe_mode_e'($urandom_range(3));
               if ($urandom_range(4) == 0) begin
                  bus.req_valid_i = 1'b0;
                  @(posedge clk); #1;
               end
               send(coeff_t'($urandom), coeff_t'($urandom), coeff_t'($urandom), coeff_t'($urandom), m, 300, w);
            end
            bus.req_valid_i = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.rsp_ready_i = 1'($urandom_range(1));
            end
            bus.rsp_ready_i = 1'b1;
         end
      join
      wait_drain(2000);
      checks++; if (rsp_seen - seen0 !== N_RAND) begin failures++; $display("FAIL rand_rsp_count: got %0d required %0d", rsp_seen - seen0, N_RAND); end
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL rand_sb_left: got %0d pending required 0", sb_q.size()); end
   endtask

   initial begin
      bus.req_valid_i = 1'b0;
      bus.req_a_i     = '0;
      bus.req_b_i     = '0;
      bus.req_w_i     = '0;
      bus.req_tf_i    = '0;
      bus.req_mode_i  = PE_MODE_NTT;
      bus.rsp_ready_i = 1'b1;
      test_reset();
      test_stream();
      test_mode_switch();
      test_backpressure();
      test_ghost();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
